// File: rtl/rr_arbiter_pkg.sv
// Shared sizes and types for the four-way round-robin arbiter.
package rr_arbiter_pkg;

  localparam int N_REQ = 4;
  localparam int PTR_W = 2;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [N_REQ-1:0] vec_t;

  // Index of the set bit in a one-hot vector; zero for an all-zero vector.
  function automatic ptr_t onehot_to_ptr(input vec_t oh);
    ptr_t p;
    p = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) p = ptr_t'(i);
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr+1, wrapping 3->0.
module rr_pick
  import rr_arbiter_pkg::*;
(
  input  vec_t req_i,
  input  ptr_t ptr_i,
  output vec_t gnt_o,
  output logic vld_o
);

  ptr_t idx;

  // Walk the search order backwards so the earliest candidate overwrites later ones.
  always_comb begin
    gnt_o = '0;
    idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = ptr_i + ptr_t'(i + 1);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter, registered one-hot grants, one cycle req->gnt.
// RR_ARBITER_HOLD_EN: a holder keeps its grant while its request stays high.
module rr_arbiter
  import rr_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req3,
  input  logic req2,
  input  logic req1,
  input  logic req0,
  output logic gnt3,
  output logic gnt2,
  output logic gnt1,
  output logic gnt0
);

  vec_t req_v;
  vec_t pick_gnt;
  logic pick_vld;
  vec_t gnt_d, gnt_q;
  ptr_t ptr_d, ptr_q;

  assign req_v = {req3, req2, req1, req0};

  rr_pick u_pick (
    .req_i (req_v),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .vld_o (pick_vld)
  );

  always_comb begin
    gnt_d = pick_gnt;
    ptr_d = pick_vld ? onehot_to_ptr(pick_gnt) : ptr_q;
`ifdef RR_ARBITER_HOLD_EN
    // ptr_q already names the holder, so freezing it makes the next search start at holder+1.
    if (|(gnt_q & req_v)) begin
      gnt_d = gnt_q;
      ptr_d = ptr_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_q <= '0;
      ptr_q <= ptr_t'(N_REQ - 1);
    end else begin
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt0 = gnt_q[0];
  assign gnt1 = gnt_q[1];
  assign gnt2 = gnt_q[2];
  assign gnt3 = gnt_q[3];

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with a scoreboard queue of expected grant vectors.
module tb_rr_arbiter;

  logic clk;
  logic rst;
  logic req3, req2, req1, req0;
  logic gnt3, gnt2, gnt1, gnt0;

  int checks;
  int failures;
  logic [3:0] exp_q[$];

  rr_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .req3 (req3),
    .req2 (req2),
    .req1 (req1),
    .req0 (req0),
    .gnt3 (gnt3),
    .gnt2 (gnt2),
    .gnt1 (gnt1),
    .gnt0 (gnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] gnt_vec();
    return {gnt3, gnt2, gnt1, gnt0};
  endfunction

  task automatic set_req(input logic [3:0] r);
    {req3, req2, req1, req0} = r;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Drive a request vector at the falling edge, queue the expected grant,
  // then pop and compare just after the rising edge that samples it.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] exp);
    logic [3:0] e;
    @(negedge clk);
    set_req(r);
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard empty observed=%b", tag, gnt_vec());
    end else begin
      e = exp_q.pop_front();
      check(tag, gnt_vec(), e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    set_req(4'b0000);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    set_req(4'b0000);

    // Reset held with random requests: no grants.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_req(4'($urandom_range(0, 15)));
      @(posedge clk);
      #1;
      check("reset_hold", gnt_vec(), 4'b0000);
    end
    @(negedge clk);
    rst = 1'b1;
    set_req(4'b0000);

    // Single requester, then drop.
    step("single0_a", 4'b0001, 4'b0001);
    step("single0_b", 4'b0001, 4'b0001);
    step("single0_c", 4'b0001, 4'b0001);
    step("single0_drop", 4'b0000, 4'b0000);

    // Asynchronous reset mid-operation clears grants without a clock edge.
    step("pre_async", 4'b0010, 4'b0010);
    #2;
    rst = 1'b0;
    #1;
    check("async_clear", gnt_vec(), 4'b0000);
    @(negedge clk);
    set_req(4'b1111);
    @(posedge clk);
    #1;
    check("reset_ignores_req", gnt_vec(), 4'b0000);
    @(negedge clk);
    rst = 1'b1;
    set_req(4'b0000);

`ifndef RR_ARBITER_HOLD_EN
    // Full rotation from reset.
    step("rot0", 4'b1111, 4'b0001);
    step("rot1", 4'b1111, 4'b0010);
    step("rot2", 4'b1111, 4'b0100);
    step("rot3", 4'b1111, 4'b1000);
    step("rot4", 4'b1111, 4'b0001);
    step("rot5", 4'b1111, 4'b0010);
    step("rot6", 4'b1111, 4'b0100);
    step("rot7", 4'b1111, 4'b1000);

    // Wrap and skip: last grant to unit 1, then units 3 and 0 compete.
    step("set_ptr1", 4'b0010, 4'b0010);
    step("wrap_a", 4'b1001, 4'b1000);
    step("wrap_b", 4'b1001, 4'b0001);
    step("wrap_c", 4'b1001, 4'b1000);
    step("idle", 4'b0000, 4'b0000);

    // Mixed pattern; pointer is 3 here.
    step("mix_01a", 4'b0011, 4'b0001);
    step("mix_01b", 4'b0011, 4'b0010);
    step("mix_02a", 4'b0101, 4'b0100);
    step("mix_02b", 4'b0101, 4'b0001);
    step("mix_03a", 4'b1001, 4'b1000);
    step("mix_03b", 4'b1001, 4'b0001);
    step("mix_0", 4'b0001, 4'b0001);
    step("mix_none", 4'b0000, 4'b0000);
`else
    // Burst hold: unit 0 keeps the grant while unit 1 waits.
    step("hold_a", 4'b0011, 4'b0001);
    step("hold_b", 4'b0011, 4'b0001);
    step("hold_c", 4'b0011, 4'b0001);
    step("hold_d", 4'b0011, 4'b0001);
    step("hold_release", 4'b0010, 4'b0010);
    step("hold_1", 4'b1010, 4'b0010);
    step("hold_1_drop", 4'b1000, 4'b1000);
    step("hold_3", 4'b1001, 4'b1000);
    step("hold_3_drop", 4'b0001, 4'b0001);
    step("hold_none", 4'b0000, 4'b0000);
`endif

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
